// File: rtl/cv32e40p_hamming_corrector.sv
// Hamming(38,32) decode/correct stage: two-stage valid/ready pipeline with single-bit correction.
// Define CV32E40P_ECC_ERR_LOG_EN to build the saturating error counters and first-error log.
module cv32e40p_hamming_corrector #(
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [37:0]      code_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      data_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             corr_o,
    output logic             uncorr_o,
    output logic [5:0]       syndrome_o,
    input  logic             clr_i,
    output logic [CNT_W-1:0] corr_cnt_o,
    output logic [CNT_W-1:0] uncorr_cnt_o,
    output logic             err_log_valid_o,
    output logic [5:0]       err_log_syn_o,
    output logic [TAG_W-1:0] err_log_tag_o
);

    // Position of data bit idx: the (idx+1)-th integer >= 3 that is not a power of two.
    function automatic logic [5:0] data_pos(input int unsigned idx);
        int unsigned cnt;
        logic [5:0]  pos;
        cnt = 0;
        pos = '0;
        for (int unsigned n = 3; n < 64; n++) begin
            if ((n & (n - 1)) != 0) begin
                if (cnt == idx) pos = n[5:0];
                cnt++;
            end
        end
        return pos;
    endfunction

    function automatic logic [5:0] calc_check(input logic [31:0] d);
        logic [5:0] chk;
        logic [5:0] pos;
        chk = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            pos = data_pos(i);
            for (int unsigned k = 0; k < 6; k++) begin
                if (pos[k]) chk[k] = chk[k] ^ d[i];
            end
        end
        return chk;
    endfunction

    logic             s1_v;
    logic             s2_v;
    logic             s1_adv;
    logic             s2_adv;
    logic [37:0]      s1_code;
    logic [TAG_W-1:0] s1_tag;
    logic [5:0]       s1_syn;
    logic [5:0]       syn_c;
    logic [31:0]      data_c;
    logic             corr_c;
    logic             uncorr_c;

    assign s2_adv      = !s2_v || out_ready_i;
    assign s1_adv      = !s1_v || s2_adv;
    assign in_ready_o  = s1_adv;
    assign out_valid_o = s2_v;

    assign syn_c = calc_check(code_i[31:0]) ^ code_i[37:32];

    // Power-of-two syndromes match no data position, so check-bit errors leave data untouched.
    always_comb begin
        data_c   = s1_code[31:0];
        corr_c   = 1'b0;
        uncorr_c = 1'b0;
        if (s1_syn > 6'd38) begin
            uncorr_c = 1'b1;
        end else if (s1_syn != 6'd0) begin
            corr_c = 1'b1;
            for (int unsigned i = 0; i < 32; i++) begin
                if (s1_syn == data_pos(i)) data_c[i] = ~s1_code[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s1_code <= '0;
            s1_tag  <= '0;
            s1_syn  <= '0;
        end else if (s1_adv) begin
            s1_v <= in_valid_i;
            if (in_valid_i) begin
                s1_code <= code_i;
                s1_tag  <= tag_i;
                s1_syn  <= syn_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v       <= 1'b0;
            data_o     <= '0;
            tag_o      <= '0;
            corr_o     <= 1'b0;
            uncorr_o   <= 1'b0;
            syndrome_o <= '0;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                data_o     <= data_c;
                tag_o      <= s1_tag;
                corr_o     <= corr_c;
                uncorr_o   <= uncorr_c;
                syndrome_o <= s1_syn;
            end
        end
    end

`ifdef CV32E40P_ECC_ERR_LOG_EN
    logic out_hs;
    assign out_hs = out_valid_o && out_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt_o      <= '0;
            uncorr_cnt_o    <= '0;
            err_log_valid_o <= 1'b0;
            err_log_syn_o   <= '0;
            err_log_tag_o   <= '0;
        end else if (clr_i) begin
            corr_cnt_o      <= '0;
            uncorr_cnt_o    <= '0;
            err_log_valid_o <= 1'b0;
            err_log_syn_o   <= '0;
            err_log_tag_o   <= '0;
        end else if (out_hs) begin
            if (corr_o && (corr_cnt_o != '1))     corr_cnt_o   <= corr_cnt_o + CNT_W'(1);
            if (uncorr_o && (uncorr_cnt_o != '1)) uncorr_cnt_o <= uncorr_cnt_o + CNT_W'(1);
            if ((corr_o || uncorr_o) && !err_log_valid_o) begin
                err_log_valid_o <= 1'b1;
                err_log_syn_o   <= syndrome_o;
                err_log_tag_o   <= tag_o;
            end
        end
    end
`else
    logic unused_clr;
    assign unused_clr      = clr_i;
    assign corr_cnt_o      = '0;
    assign uncorr_cnt_o    = '0;
    assign err_log_valid_o = 1'b0;
    assign err_log_syn_o   = '0;
    assign err_log_tag_o   = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_hamming_corrector.sv
// Self-checking bench for cv32e40p_hamming_corrector: vector table, directed sequences and random traffic
// against a position-based Hamming reference model (CV32E40P_ECC_ERR_LOG_EN selects the log/counter expectations).
module tb_cv32e40p_hamming_corrector;
    localparam int TAG_W = 5;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [37:0]      code_i;
    logic [TAG_W-1:0] tag_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [31:0]      data_o;
    logic [TAG_W-1:0] tag_o;
    logic             corr_o;
    logic             uncorr_o;
    logic [5:0]       syndrome_o;
    logic             clr_i;
    logic [CNT_W-1:0] corr_cnt_o;
    logic [CNT_W-1:0] uncorr_cnt_o;
    logic             err_log_valid_o;
    logic [5:0]       err_log_syn_o;
    logic [TAG_W-1:0] err_log_tag_o;

    always #5 clk = ~clk;

    cv32e40p_hamming_corrector #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .code_i(code_i), .tag_i(tag_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .data_o(data_o), .tag_o(tag_o), .corr_o(corr_o), .uncorr_o(uncorr_o),
        .syndrome_o(syndrome_o), .clr_i(clr_i), .corr_cnt_o(corr_cnt_o),
        .uncorr_cnt_o(uncorr_cnt_o), .err_log_valid_o(err_log_valid_o),
        .err_log_syn_o(err_log_syn_o), .err_log_tag_o(err_log_tag_o)
    );

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic             corr;
        logic             uncorr;
        logic [5:0]       syn;
    } exp_t;

    typedef struct {
        logic [37:0] code;
        logic [31:0] exp_data;
        logic        exp_corr;
        logic        exp_uncorr;
        logic [5:0]  exp_syn;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    bit   stall = 1'b0;
    exp_t held;
    int   m_corr = 0;
    int   m_uncorr = 0;
    bit   m_logv = 1'b0;
    logic [5:0]       m_lsyn = '0;
    logic [TAG_W-1:0] m_ltag = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Codeword viewed as positions 1..38: powers of two hold check bits, the rest hold data in order.
    function automatic logic [38:1] to_positions(input logic [37:0] c);
        logic [38:1] w;
        int unsigned d = 0;
        int unsigned k = 0;
        for (int unsigned p = 1; p <= 38; p++) begin
            if ((p & (p - 1)) == 0) begin w[p] = c[32 + k]; k++; end
            else begin w[p] = c[d]; d++; end
        end
        return w;
    endfunction

    // Syndrome = XOR of the positions of all set bits.
    function automatic logic [5:0] ref_syn(input logic [37:0] c);
        logic [38:1] w;
        logic [5:0]  s = '0;
        w = to_positions(c);
        for (int unsigned p = 1; p <= 38; p++) if (w[p]) s = s ^ 6'(p);
        return s;
    endfunction

    function automatic logic [37:0] encode(input logic [31:0] d);
        return {ref_syn({6'b0, d}), d};
    endfunction

    function automatic exp_t model(input logic [37:0] c, input logic [TAG_W-1:0] t);
        exp_t e;
        logic [38:1] w;
        int unsigned d = 0;
        w = to_positions(c);
        e.syn    = ref_syn(c);
        e.tag    = t;
        e.corr   = (e.syn != 0) && (e.syn <= 38);
        e.uncorr = (e.syn > 38);
        if (e.corr) w[e.syn] = ~w[e.syn];
        e.data = '0;
        for (int unsigned p = 1; p <= 38; p++) begin
            if ((p & (p - 1)) != 0) begin e.data[d] = w[p]; d++; end
        end
        return e;
    endfunction

    task automatic step(output bit acc);
        bit   ohs;
        exp_t e;
        #1;
        chk("corr_cnt", corr_cnt_o, m_corr);
        chk("uncorr_cnt", uncorr_cnt_o, m_uncorr);
        chk("log_valid", err_log_valid_o, m_logv);
        if (m_logv) begin
            chk("log_syn", err_log_syn_o, m_lsyn);
            chk("log_tag", err_log_tag_o, m_ltag);
        end
        if (stall) begin
            chk("stall_valid", out_valid_o, 1);
            chk("stall_data", data_o, held.data);
            chk("stall_tag", tag_o, held.tag);
            chk("stall_flags", {corr_o, uncorr_o, syndrome_o}, {held.corr, held.uncorr, held.syn});
        end
        acc = in_valid_i && in_ready_o;
        ohs = out_valid_o && out_ready_i;
        if (ohs) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got data %0h with empty scoreboard", data_o);
            end else begin
                e = q.pop_front();
                chk("sb_data", data_o, e.data);
                chk("sb_tag", tag_o, e.tag);
                chk("sb_corr", corr_o, e.corr);
                chk("sb_uncorr", uncorr_o, e.uncorr);
                chk("sb_syn", syndrome_o, e.syn);
            end
        end
        stall = out_valid_o && !out_ready_i;
        held  = '{data_o, tag_o, corr_o, uncorr_o, syndrome_o};
        if (acc) q.push_back(model(code_i, tag_i));
`ifdef CV32E40P_ECC_ERR_LOG_EN
        if (clr_i) begin
            m_corr = 0; m_uncorr = 0; m_logv = 0; m_lsyn = '0; m_ltag = '0;
        end else if (ohs && e.syn !== 6'bx) begin
            if (e.corr && m_corr < CMAX) m_corr++;
            if (e.uncorr && m_uncorr < CMAX) m_uncorr++;
            if ((e.corr || e.uncorr) && !m_logv) begin
                m_logv = 1; m_lsyn = e.syn; m_ltag = e.tag;
            end
        end
`endif
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [37:0] c, input logic [TAG_W-1:0] t);
        bit acc = 0;
        in_valid_i = 1; code_i = c; tag_i = t;
        for (int n = 0; n < 50 && !acc; n++) step(acc);
        if (!acc) begin
            errors++; checks++;
            $display("FAIL send_timeout: got no acceptance expected in_ready_o");
        end
        in_valid_i = 0;
    endtask

    task automatic drain();
        bit acc;
        out_ready_i = 1; in_valid_i = 0;
        for (int n = 0; n < 100 && q.size() > 0; n++) step(acc);
        for (int n = 0; n < 3; n++) step(acc);
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic reset_now();
        rst_n = 0;
        #1;
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_in_ready", in_ready_o, 1);
        chk("rst_data_tag", {data_o, tag_o}, 0);
        chk("rst_flags", {corr_o, uncorr_o, syndrome_o}, 0);
        chk("rst_cnts", {corr_cnt_o, uncorr_cnt_o}, 0);
        chk("rst_log", {err_log_valid_o, err_log_syn_o, err_log_tag_o}, 0);
        q.delete();
        stall = 0; m_corr = 0; m_uncorr = 0; m_logv = 0; m_lsyn = '0; m_ltag = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    vec_t vecs[10];
    logic [37:0] base;
    logic [37:0] c;
    bit          acc;

    initial begin
        rst_n = 0; in_valid_i = 0; code_i = '0; tag_i = '0; out_ready_i = 1; clr_i = 0;
        @(negedge clk);
        reset_now();

        base = encode(32'hDEADBEEF);
        vecs[0] = '{base, 32'hDEADBEEF, 0, 0, 6'd0};
        c = encode(32'h1); c[0] = 0;
        vecs[1] = '{c, 32'h1, 1, 0, 6'd3};
        c = encode(32'h1); c[31] = 1;
        vecs[2] = '{c, 32'h1, 1, 0, 6'd38};
        c = base; c[35] = ~c[35];
        vecs[3] = '{c, 32'hDEADBEEF, 1, 0, 6'd8};
        c = base; c[37:32] = c[37:32] ^ 6'd45;
        vecs[4] = '{c, 32'hDEADBEEF, 0, 1, 6'd45};
        c = encode(32'hFFFFFFFF); c[10] = 0;
        vecs[5] = '{c, 32'hFFFFFFFF, 1, 0, 6'd15};
        c = encode(32'h12345678); c[26] = ~c[26];
        vecs[6] = '{c, 32'h12345678, 1, 0, 6'd33};
        c = encode(32'h0F0F0F0F); c[32] = ~c[32];
        vecs[7] = '{c, 32'h0F0F0F0F, 1, 0, 6'd1};
        c = encode(32'h0); c[37:32] = 6'd63;
        vecs[8] = '{c, 32'h0, 0, 1, 6'd63};
        c = encode(32'hCAFEF00D); c[37:32] = c[37:32] ^ 6'd39;
        vecs[9] = '{c, 32'hCAFEF00D, 0, 1, 6'd39};

        for (int i = 0; i < 10; i++) begin
            send(vecs[i].code, 5'(i));
            chk("lat_not_yet", out_valid_o, 0);
            step(acc);
            chk("lat_valid", out_valid_o, 1);
            chk("vec_data", data_o, vecs[i].exp_data);
            chk("vec_corr", corr_o, vecs[i].exp_corr);
            chk("vec_uncorr", uncorr_o, vecs[i].exp_uncorr);
            chk("vec_syn", syndrome_o, vecs[i].exp_syn);
            step(acc);
        end
        drain();

        // Backpressure: out_ready_i low for the first three cycles.
        begin
            logic [37:0] bp[4];
            int idx = 0;
            for (int i = 0; i < 4; i++) begin
                bp[i] = encode(32'h1111_0000 * 32'(i + 1));
                if (i == 2) bp[i][7] = ~bp[i][7];
            end
            for (int cyc = 0; cyc < 40 && (idx < 4 || q.size() > 0); cyc++) begin
                in_valid_i  = (idx < 4);
                code_i      = bp[(idx < 4) ? idx : 0];
                tag_i       = 5'(20 + idx);
                out_ready_i = (cyc >= 3);
                #1;
                if (cyc == 2) chk("bp_in_ready_low", in_ready_o, 0);
                step(acc);
                if (acc) idx++;
            end
            chk("bp_all_sent", idx, 4);
            drain();
        end

        // Saturation and first-error log.
        clr_i = 1; step(acc); clr_i = 0;
        for (int i = 0; i < 5; i++) begin
            c = encode(32'hA5A5A5A5); c[4 + i] = ~c[4 + i];
            send(c, 5'(17 + i));
        end
        drain();
`ifdef CV32E40P_ECC_ERR_LOG_EN
        chk("sat_corr_cnt", corr_cnt_o, CMAX);
        chk("sat_log_valid", err_log_valid_o, 1);
        chk("sat_log_syn", err_log_syn_o, 9);
        chk("sat_log_tag", err_log_tag_o, 17);
`else
        chk("off_corr_cnt", corr_cnt_o, 0);
        chk("off_log", {err_log_valid_o, err_log_syn_o, err_log_tag_o}, 0);
`endif

        // Clear coinciding with an error handshake.
        clr_i = 1; step(acc); clr_i = 0;
        c = encode(32'h5A5A5A5A); c[37:32] = c[37:32] ^ 6'd50;
        send(c, 5'd3);
        step(acc);
        chk("clr_hs_valid", out_valid_o, 1);
        clr_i = 1; step(acc); clr_i = 0;
        chk("clr_cnts", {corr_cnt_o, uncorr_cnt_o}, 0);
        chk("clr_log_valid", err_log_valid_o, 0);
        drain();

        // Random traffic with random error injection.
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [31:0] d;
            d = $urandom;
            c = encode(d);
            case ($urandom_range(0, 3))
                0: ;
                1: c[$urandom_range(0, 31)] ^= 1'b1;
                2: c[32 + $urandom_range(0, 5)] ^= 1'b1;
                default: c[37:32] = c[37:32] ^ 6'($urandom_range(0, 63));
            endcase
            in_valid_i  = ($urandom_range(0, 3) != 0);
            code_i      = c;
            tag_i       = 5'($urandom);
            out_ready_i = ($urandom_range(0, 9) < 7);
            clr_i       = ($urandom_range(0, 49) == 0);
            step(acc);
        end
        clr_i = 0;
        drain();

        // Reset with both stages full, then 2-cycle latency after release.
        out_ready_i = 0;
        in_valid_i = 1; code_i = encode(32'h77); tag_i = 5'd1; step(acc);
        code_i = encode(32'h88); tag_i = 5'd2; step(acc);
        in_valid_i = 0;
        chk("pre_rst_valid", out_valid_o, 1);
        reset_now();
        out_ready_i = 1;
        send(encode(32'h0BADCAFE), 5'd9);
        chk("post_rst_lat1", out_valid_o, 0);
        step(acc);
        chk("post_rst_lat2", out_valid_o, 1);
        chk("post_rst_data", data_o, 32'h0BADCAFE);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected completion");
        $fatal(1, "timeout");
    end
endmodule
